// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex nibbles from a scanned, active-low seven-segment bus into a register bank.
// Optional SEG_DECODE_ERR_COUNT_EN adds a saturating err_count output.
module seven_seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clear_flags,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    bad_pattern,
`ifdef SEG_DECODE_ERR_COUNT_EN
    output logic                    anode_err,
    output logic [7:0]              err_count
`else
    output logic                    anode_err
`endif
);

    localparam logic [1:0] ST_WAIT    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;
    logic [7:0]            stable_cnt;
    logic [1:0]            state, state_next;
    logic [NUM_DIGITS-1:0] seen;

    logic                  sample_changing;
    logic [NUM_DIGITS-1:0] an_low;
    logic                  any_low, one_low;
    logic [4:0]            decoded;
    logic                  legal;
    logic [3:0]            nibble;
    logic                  capture, cap_digit, cap_bad, cap_multi;
    logic [NUM_DIGITS-1:0] seen_merged;
    logic                  frame_hit;

    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    // Looking at stage 1 lets the counter restart on the same edge the sample changes.
    assign sample_changing = (seg_s1 != seg_s2) || (an_s1 != an_s2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
        end else if (sample_changing) begin
            stable_cnt <= 8'd1;
        end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:    if (stable_cnt == STABLE_MAX && !sample_changing) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = sample_changing ? ST_WAIT : ST_HOLD;
            ST_HOLD:    if (sample_changing) state_next = ST_WAIT;
            default:    state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    assign an_low    = ~an_s2;
    assign any_low   = |an_low;
    assign one_low   = any_low && ((an_low & (an_low - 1'b1)) == '0);
    assign decoded   = decode_seg(seg_s2);
    assign legal     = decoded[4];
    assign nibble    = decoded[3:0];

    assign capture   = (state == ST_CAPTURE);
    assign cap_digit = capture && one_low;
    assign cap_bad   = cap_digit && !legal;
    assign cap_multi = capture && any_low && !one_low;

    // Clear drops the old mask but never the bit set by a coincident capture.
    assign seen_merged = (clear_flags ? '0 : seen) | (cap_digit ? an_low : '0);
    assign frame_hit   = cap_digit && (seen_merged == '1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digits_out  <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap_digit && an_low[i]) begin
                    digit_valid[i] <= legal;
                    if (legal) begin
                        digits_out[4*i +: 4] <= nibble;
                    end
                end
            end
            seen        <= frame_hit ? '0 : seen_merged;
            frame_done  <= frame_hit;
            bad_pattern <= cap_bad | (bad_pattern & ~clear_flags);
            anode_err   <= cap_multi | (anode_err & ~clear_flags);
        end
    end

`ifdef SEG_DECODE_ERR_COUNT_EN
    logic err_event;
    assign err_event = cap_bad | cap_multi;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clear_flags) begin
            err_count <= err_event ? 8'd1 : 8'd0;
        end else if (err_event && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seven_seg_scan_decoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        clear_flags;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        bad_pattern;
    logic        anode_err;
`ifdef SEG_DECODE_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .clear_flags (clear_flags),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
`ifdef SEG_DECODE_ERR_COUNT_EN
        .anode_err   (anode_err),
        .err_count   (err_count)
`else
        .anode_err   (anode_err)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        int          cycles;
        bit          clr;
        logic [15:0] digits;
        logic [3:0]  valid;
        bit          bad;
        bit          aerr;
        int          frames;
        int          errs;
    } row_t;

    row_t rows[14];
    row_t exp_q[$];

    int total  = 0;
    int passed = 0;
    int frames = 0;

    always @(negedge clock) begin
        if (reset_n === 1'b1 && frame_done === 1'b1) frames++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digits"}, 32'(digits_out), 32'h0);
        check({tag, "_valid"}, 32'(digit_valid), 32'h0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        check({tag, "_bad"}, 32'(bad_pattern), 32'h0);
        check({tag, "_anode_err"}, 32'(anode_err), 32'h0);
`ifdef SEG_DECODE_ERR_COUNT_EN
        check({tag, "_err_count"}, 32'(err_count), 32'h0);
`endif
    endtask

    task automatic apply_row(input row_t r);
        row_t e;
        @(posedge clock); #1;
        seg_in      = r.seg;
        an_in       = r.an;
        clear_flags = r.clr;
        exp_q.push_back(r);
        repeat (r.cycles) begin
            @(posedge clock); #1;
            clear_flags = 1'b0;
        end
        @(negedge clock);
        e = exp_q.pop_front();
        check($sformatf("row_seg%0h_an%0h_digits", e.seg, e.an), 32'(digits_out), 32'(e.digits));
        check($sformatf("row_seg%0h_an%0h_valid", e.seg, e.an), 32'(digit_valid), 32'(e.valid));
        check($sformatf("row_seg%0h_an%0h_bad", e.seg, e.an), 32'(bad_pattern), 32'(e.bad));
        check($sformatf("row_seg%0h_an%0h_anode_err", e.seg, e.an), 32'(anode_err), 32'(e.aerr));
        check($sformatf("row_seg%0h_an%0h_frames", e.seg, e.an), 32'(frames), 32'(e.frames));
`ifdef SEG_DECODE_ERR_COUNT_EN
        check($sformatf("row_seg%0h_an%0h_err_count", e.seg, e.an), 32'(err_count), 32'(e.errs));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          seg    an    cyc clr digits    valid bad aerr fr err
        rows[0]  = '{7'h7F, 4'hF, 20, 0, 16'h0000, 4'h0, 0, 0, 0, 0};
        rows[1]  = '{7'h12, 4'hE,  8, 0, 16'h0005, 4'h1, 0, 0, 0, 0};
        rows[2]  = '{7'h46, 4'hD,  8, 0, 16'h00C5, 4'h3, 0, 0, 0, 0};
        rows[3]  = '{7'h40, 4'hB,  8, 0, 16'h00C5, 4'h7, 0, 0, 0, 0};
        rows[4]  = '{7'h0E, 4'h7,  8, 0, 16'hF0C5, 4'hF, 0, 0, 1, 0};
        rows[5]  = '{7'h7F, 4'hF,  8, 0, 16'hF0C5, 4'hF, 0, 0, 1, 0};
        rows[6]  = '{7'h7E, 4'hE, 10, 0, 16'hF015, 4'hE, 1, 0, 1, 1};
        rows[7]  = '{7'h7F, 4'hC, 10, 0, 16'hF015, 4'hE, 1, 1, 1, 2};
        rows[8]  = '{7'h7F, 4'hF, 10, 1, 16'hF015, 4'hE, 0, 0, 1, 0};
        rows[9]  = '{7'h79, 4'hE,  8, 0, 16'hF011, 4'hF, 0, 0, 1, 0};
        rows[10] = '{7'h24, 4'hE,  8, 0, 16'hF012, 4'hF, 0, 0, 1, 0};
        rows[11] = '{7'h30, 4'hD,  8, 0, 16'hF032, 4'hF, 0, 0, 1, 0};
        rows[12] = '{7'h19, 4'hB,  8, 0, 16'hF432, 4'hF, 0, 0, 1, 0};
        rows[13] = '{7'h02, 4'h7,  8, 0, 16'h6432, 4'hF, 0, 0, 2, 0};

        reset_n     = 1'b0;
        clear_flags = 1'b0;
        seg_in      = 7'h7F;
        an_in       = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            seg_in = 7'($urandom);
            an_in  = 4'($urandom);
        end
        @(negedge clock);
        check_all_zero("reset");
        seg_in = 7'h7F;
        an_in  = 4'hF;
        @(posedge clock); #1;
        reset_n = 1'b1;

        apply_row(rows[0]);

        // Latency from input change to register update.
        @(posedge clock); #1;
        seg_in = 7'h30;
        an_in  = 4'hE;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (digits_out[3:0] !== 4'h3 && n < 20);
        check("latency_cycles", 32'(n), 32'd7);
        repeat (10 - n) @(posedge clock);
        @(negedge clock);
        check("single_digits", 32'(digits_out), 32'h0003);
        check("single_valid", 32'(digit_valid), 32'h1);
        check("single_frames", 32'(frames), 32'd0);

        for (int i = 1; i <= 5; i++) apply_row(rows[i]);

        // Segment bus toggling every two clocks must never be captured.
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            seg_in = (k % 2 == 1) ? 7'h24 : 7'h79;
            an_in  = 4'hD;
            @(posedge clock);
        end
        @(negedge clock);
        check("glitch_digits", 32'(digits_out), 32'hF0C5);
        check("glitch_valid", 32'(digit_valid), 32'hF);
        @(posedge clock); #1;
        seg_in = 7'h79;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("post_glitch_digits", 32'(digits_out), 32'hF015);

        for (int i = 6; i <= 13; i++) apply_row(rows[i]);

`ifdef SEG_DECODE_ERR_COUNT_EN
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            seg_in = (k % 2 == 1) ? 7'h7D : 7'h7E;
            an_in  = 4'hE;
            repeat (8) @(posedge clock);
        end
        @(negedge clock);
        check("sat_err_count", 32'(err_count), 32'd255);
        check("sat_bad", 32'(bad_pattern), 32'h1);
`endif

        // Reset in the middle of a stable window.
        @(posedge clock); #1;
        seg_in = 7'h40;
        an_in  = 4'hE;
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        seg_in = 7'h7F;
        an_in  = 4'hF;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("after_reset_digits", 32'(digits_out), 32'h0);
        check("after_reset_valid", 32'(digit_valid), 32'h0);
        check("after_reset_frames", 32'(frames), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a multiplexed, active-low seven-segment bus (segment lines plus per-digit anode enables) and recovers the hex nibble shown on each digit.
- Used as an on-chip display self-check and for capturing external scanned-display outputs.
- Results are held in a register bank, and a pulse marks each complete scan frame.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (anode lines); legal range 1..8.
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before capture; legal range 1..255.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  active-low segments; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- an_in  input  NUM_DIGITS  active-low digit enables; bit i selects digit i.
- clear_flags  input  1  synchronous clear of sticky flags and the frame-seen mask.
- digits_out  output  4*NUM_DIGITS  decoded nibbles; digit i occupies [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i=1 means the last capture of digit i held a legal hex pattern.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last frame.
- bad_pattern  output  1  sticky; a capture held a non-hex pattern.
- anode_err  output  1  sticky; a stable sample had more than one anode low.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - digits_out=0, digit_valid=0, frame_done=0, bad_pattern=0, anode_err=0.
  - Synchronizers load all-ones (blank, no digit selected); stability counter=0; seen mask=0; FSM=WAIT.
- Input conditioning: seg_in and an_in each pass through a 2-flop synchronizer. The "sample" below is the second-stage value.
- Stability counter:
  - Resets to 1 whenever the sample differs from the previous cycle's sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM has three states:
  - WAIT: counter below STABLE_CYCLES. Go to CAPTURE when the counter reaches STABLE_CYCLES.
  - CAPTURE: one cycle; performs the capture rules below, then goes to HOLD.
  - HOLD: stays until the sample changes, then goes to WAIT. Exactly one capture per stable window.
- Capture rules, by anode pattern:
  - Exactly one an bit low (digit k): decode seg. If legal, write nibble to digit k, set digit_valid[k]=1, set seen[k]. If illegal, leave nibble k unchanged, clear digit_valid[k], set bad_pattern, set seen[k].
  - All an bits high: no write; seen unchanged.
  - Two or more an bits low: no write; anode_err set.
- Decode table (seg as hex, active-low, bit6..bit0):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - All other codes are illegal.
- Latency:
  - A segment/anode change is visible on digits_out 2 (sync) + STABLE_CYCLES + 1 clocks after the input edge.
  - digits_out and digit_valid update on the clock edge ending CAPTURE.
- Frame completion:
  - When the capture makes seen all-ones, frame_done pulses high for exactly one cycle, coincident with the digits_out update.
  - seen clears to 0 on that same edge.
  - A repeated capture of an already-seen digit overwrites its nibble and does not double-count.
- clear_flags:
  - Clears bad_pattern, anode_err and seen.
  - If it coincides with a setting event, the set wins for the flags, and seen reflects only the new capture.
  - Does not clear digits_out or digit_valid.
- Reset mid-window: all state returns to reset values immediately; no partial capture.

Optional Feature:
- Macro: SEG_DECODE_ERR_COUNT_EN.
- When defined:
  - Adds output err_count [7:0].
  - err_count increments once per capture with an illegal pattern or multiple anodes low, saturating at 255.
  - Cleared by reset and by clear_flags; on a coincident clear and error event it loads 1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with random inputs → all outputs 0. Release, hold seg=7F, an=F for 20 clocks → digits_out=0000, frame_done never asserts.
- Single digit: an=E, seg=30 held 10 clocks (STABLE_CYCLES=4) → nibble0=3, digit_valid=0001, update exactly 7 clocks after the input edge, one capture only.
- Full frame: scan digits 0..3 with 12, 46, 00, 0E, 8 clocks each → digits_out=F0C5, digit_valid=F, one frame_done pulse on the digit-3 capture.
- Glitch rejection: seg toggles every 2 clocks for 20 clocks with an=D → no capture; then seg=79 stable → nibble1=1.
- Errors: an=E with seg=7E (illegal) → bad_pattern=1, digit_valid[0]=0, nibble unchanged. an=C stable → anode_err=1, no write. clear_flags pulse → both 0. With SEG_DECODE_ERR_COUNT_EN defined, err_count goes 2 → 0.
- Saturation (macro on): 300 illegal captures → err_count=255, not wrapped.
